// File: rtl/stage_classifier_fetch.sv
// Stage classifier ROM reader: streams one stage's records out of ROM, hides the read latency
// and packs each record into one wide word. Optional XOR record check: CLASSIFIER_FETCH_CHECKSUM_EN.
module stage_classifier_fetch #(
  parameter int ADDR_WIDTH           = 12,
  parameter int DATA_WIDTH           = 8,
  parameter int WORDS_PER_CLASSIFIER = 18,
  parameter int ROM_LATENCY          = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         i_start,
  input  logic [ADDR_WIDTH-1:0]                        i_base_addr,
  input  logic [DATA_WIDTH-1:0]                        i_num_classifiers,
  output logic [ADDR_WIDTH-1:0]                        o_rom_address,
  input  logic [DATA_WIDTH-1:0]                        i_rom_q,
  output logic [WORDS_PER_CLASSIFIER*DATA_WIDTH-1:0]   o_record,
  output logic                                         o_record_valid,
  input  logic                                         i_record_ready,
  output logic [DATA_WIDTH-1:0]                        o_classifier_index,
  output logic                                         o_last_classifier,
  output logic                                         o_busy,
  output logic                                         o_done,
  output logic                                         o_checksum_err
);

  localparam int W  = WORDS_PER_CLASSIFIER;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] W_CNT     = CW'(W);
  localparam logic [CW-1:0] LAST_WORD = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] num;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         word_cnt;
  logic [ROM_LATENCY:0]  tags;
  logic                  handshake;
  logic                  capture;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_addr;

  assign handshake = o_record_valid && i_record_ready;
  // tags[0] marks a cycle carrying a fresh address; its data arrives ROM_LATENCY cycles later
  assign capture   = tags[ROM_LATENCY];

  always_comb begin
    issue      = 1'b0;
    issue_addr = ptr;
    case (state)
      IDLE: begin
        issue      = i_start && (i_num_classifiers != '0);
        issue_addr = i_base_addr;
      end
      FETCH:   issue = (issue_cnt != W_CNT);
      HOLD:    issue = handshake && !o_last_classifier;
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      ptr                <= '0;
      num                <= '0;
      issue_cnt          <= '0;
      word_cnt           <= '0;
      tags               <= '0;
      o_rom_address      <= '0;
      o_record           <= '0;
      o_record_valid     <= 1'b0;
      o_classifier_index <= '0;
      o_last_classifier  <= 1'b0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
    end else begin
      tags   <= {tags[ROM_LATENCY-1:0], issue};
      o_done <= 1'b0;
      if (issue) begin
        o_rom_address <= issue_addr;
        ptr           <= issue_addr + 1'b1;
        issue_cnt     <= (state == FETCH) ? issue_cnt + 1'b1 : CW'(1);
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            num                <= i_num_classifiers;
            o_classifier_index <= '0;
            word_cnt           <= '0;
            o_busy             <= 1'b1;
            state              <= (i_num_classifiers != '0) ? FETCH : DONE;
          end
        end
        FETCH: begin
          if (capture) begin
            o_record[word_cnt*DATA_WIDTH +: DATA_WIDTH] <= i_rom_q;
            if (word_cnt == LAST_WORD) begin
              word_cnt          <= '0;
              o_record_valid    <= 1'b1;
              o_last_classifier <= (o_classifier_index == num - 1'b1);
              state             <= HOLD;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (handshake) begin
            o_record_valid    <= 1'b0;
            o_last_classifier <= 1'b0;
            if (o_last_classifier) begin
              state <= DONE;
            end else begin
              o_classifier_index <= o_classifier_index + 1'b1;
              state              <= FETCH;
            end
          end
        end
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLASSIFIER_FETCH_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] xor_acc;

  // Accumulator idles at zero outside FETCH, so every record starts from a clean value
  always_ff @(posedge clk) begin
    if (reset) begin
      xor_acc        <= '0;
      o_checksum_err <= 1'b0;
    end else begin
      if (state != FETCH) begin
        xor_acc <= '0;
      end else if (capture) begin
        xor_acc <= xor_acc ^ i_rom_q;
      end
      if ((state == FETCH) && capture && (word_cnt == LAST_WORD)) begin
        o_checksum_err <= ((xor_acc ^ i_rom_q) != '0);
      end else if (handshake) begin
        o_checksum_err <= 1'b0;
      end
    end
  end
`else
  assign o_checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_stage_classifier_fetch.sv
// Directed bench for stage_classifier_fetch: table of whole-stage runs plus backpressure,
// wrap/latency, reset-abort and record-checksum sequences.
module tb_stage_classifier_fetch;

  localparam int REC_BITS = 18 * 8;

`ifdef CLASSIFIER_FETCH_CHECKSUM_EN
  localparam logic CSUM_ON = 1'b1;
`else
  localparam logic CSUM_ON = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic                start;
  logic                start_l3;
  logic [11:0]         base_addr;
  logic [7:0]          num_classifiers;
  logic                ready;
  logic                flip;

  logic [11:0]         rom_address;
  logic [7:0]          rom_q;
  logic [REC_BITS-1:0] record;
  logic                record_valid;
  logic [7:0]          index;
  logic                last;
  logic                busy;
  logic                done;
  logic                checksum_err;

  logic [11:0]         rom_address_l3;
  logic [7:0]          rom_q_l3;
  logic [7:0]          rq1;
  logic [7:0]          rq2;
  logic [REC_BITS-1:0] record_l3;
  logic                record_valid_l3;
  logic [7:0]          index_l3;
  logic                last_l3;
  logic                busy_l3;
  logic                done_l3;
  logic                checksum_err_l3;

  int errors;
  int checks;

  typedef struct {
    logic [11:0] base;
    logic [7:0]  n;
    int          exp_valid;
    int          exp_done;
    int          exp_issued;
    int          mid_cycle;
  } vec_t;

  vec_t vecs[5];

  stage_classifier_fetch dut (
    .clk(clk), .reset(reset), .i_start(start), .i_base_addr(base_addr),
    .i_num_classifiers(num_classifiers), .o_rom_address(rom_address), .i_rom_q(rom_q),
    .o_record(record), .o_record_valid(record_valid), .i_record_ready(ready),
    .o_classifier_index(index), .o_last_classifier(last), .o_busy(busy),
    .o_done(done), .o_checksum_err(checksum_err)
  );

  stage_classifier_fetch #(.ROM_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .i_start(start_l3), .i_base_addr(base_addr),
    .i_num_classifiers(num_classifiers), .o_rom_address(rom_address_l3), .i_rom_q(rom_q_l3),
    .o_record(record_l3), .o_record_valid(record_valid_l3), .i_record_ready(ready),
    .o_classifier_index(index_l3), .o_last_classifier(last_l3), .o_busy(busy_l3),
    .o_done(done_l3), .o_checksum_err(checksum_err_l3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM content: low byte of address, except page 0x2xx which holds 0xA5 (optionally one bit flipped)
  function automatic logic [7:0] romWord(input logic [11:0] a);
    if (a[11:8] == 4'h2) return 8'hA5 ^ ((flip && a == 12'h215) ? 8'h08 : 8'h00);
    return a[7:0];
  endfunction

  always @(posedge clk) begin
    rom_q    <= romWord(rom_address);
    rq1      <= romWord(rom_address_l3);
    rq2      <= rq1;
    rom_q_l3 <= rq2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [11:0] b, input logic [7:0] n,
                               input logic rdy);
    start           = st;
    base_addr       = b;
    num_classifiers = n;
    ready           = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [REC_BITS-1:0] act,
                             input logic [REC_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one stage with ready held high; start is high in cycle 0
  task automatic runStage(input logic [11:0] b, input logic [7:0] n, input int exp_valid,
                          input int exp_done, input int exp_issued, input int mid_cycle);
    int first_valid, done_cycle, issued, done_cnt, busy_cnt, rec, rec_bad, addr_bad;
    logic [11:0] prev_addr;
    logic [11:0] a;
    first_valid = -1; done_cycle = -1; issued = 0; done_cnt = 0;
    busy_cnt = 0; rec = 0; rec_bad = 0; addr_bad = 0;
    prev_addr = rom_address;
    applyStimulus(1'b1, b, n, 1'b1);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (cyc == 1) start = 1'b0;
      if (cyc == mid_cycle) applyStimulus(1'b1, 12'h600, 8'd5, 1'b1);
      if (cyc == mid_cycle + 1) start = 1'b0;
      if (rom_address != prev_addr) begin
        if (rom_address !== b + 12'(issued)) addr_bad++;
        issued++;
        prev_addr = rom_address;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (record_valid) begin
        if (first_valid < 0) first_valid = cyc;
        for (int k = 0; k < 18; k++) begin
          a = b + 12'(rec * 18 + k);
          if (record[k*8 +: 8] !== a[7:0]) rec_bad++;
        end
        if (index !== 8'(rec)) rec_bad++;
        if (last !== (rec == int'(n) - 1)) rec_bad++;
        rec++;
      end
      if (done_cycle >= 0 && cyc >= done_cycle + 2) break;
    end
    checkOutput("first_valid_cycle", REC_BITS'(first_valid), REC_BITS'(exp_valid));
    checkOutput("done_cycle", REC_BITS'(done_cycle), REC_BITS'(exp_done));
    checkOutput("addresses_issued", REC_BITS'(issued), REC_BITS'(exp_issued));
    checkOutput("address_sequence_errors", REC_BITS'(addr_bad), '0);
    checkOutput("done_pulses", REC_BITS'(done_cnt), REC_BITS'(1));
    checkOutput("busy_cycles", REC_BITS'(busy_cnt), REC_BITS'(exp_done - 1));
    checkOutput("records_delivered", REC_BITS'(rec), REC_BITS'(n));
    checkOutput("record_content_errors", REC_BITS'(rec_bad), '0);
    checkOutput("busy_after_done", REC_BITS'(busy), '0);
  endtask

  initial begin
    int cyc, bad, done_seen;
    logic [REC_BITS-1:0] snap_rec;
    logic [7:0]  snap_idx;
    logic [11:0] snap_addr;
    logic [11:0] a;
    errors = 0; checks = 0; flip = 1'b0; start_l3 = 1'b0;
    reset = 1'b1;
    applyStimulus(1'b0, 12'h000, 8'd0, 1'b0);

    vecs[0] = '{12'h100, 8'd2, 20, 42, 36, -1};
    vecs[1] = '{12'h050, 8'd0, -1, 2, 0, -1};
    vecs[2] = '{12'h300, 8'd1, 20, 22, 18, -1};
    vecs[3] = '{12'h7F0, 8'd3, 20, 62, 54, -1};
    vecs[4] = '{12'h500, 8'd2, 20, 42, 36, 5};

    repeat (3) tick();
    checkOutput("reset_address", REC_BITS'(rom_address), '0);
    checkOutput("reset_record", record, '0);
    checkOutput("reset_flags", REC_BITS'({record_valid, last, busy, done, checksum_err, index}), '0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      runStage(vecs[i].base, vecs[i].n, vecs[i].exp_valid, vecs[i].exp_done,
               vecs[i].exp_issued, vecs[i].mid_cycle);
    end

    // Backpressure: ready low for 10 valid cycles, then a single-cycle ready
    applyStimulus(1'b1, 12'h400, 8'd2, 1'b0);
    cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      cyc = c;
      if (record_valid) break;
    end
    checkOutput("bp_first_valid_cycle", REC_BITS'(cyc), REC_BITS'(20));
    checkOutput("bp_record0_word0", REC_BITS'(record[7:0]), REC_BITS'(8'h00));
    snap_rec = record; snap_idx = index; snap_addr = rom_address;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (record !== snap_rec || index !== snap_idx || record_valid !== 1'b1 ||
          rom_address !== snap_addr) bad++;
    end
    checkOutput("bp_hold_stable_errors", REC_BITS'(bad), '0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checkOutput("bp_valid_drop", REC_BITS'(record_valid), '0);
    checkOutput("bp_index_after_handshake", REC_BITS'(index), REC_BITS'(1));
    cyc = 31;
    for (int c = 32; c <= 90; c++) begin
      tick();
      cyc = c;
      if (record_valid) break;
    end
    checkOutput("bp_second_valid_cycle", REC_BITS'(cyc), REC_BITS'(50));
    checkOutput("bp_second_index", REC_BITS'(index), REC_BITS'(1));
    checkOutput("bp_record1_word0", REC_BITS'(record[7:0]), REC_BITS'(8'h12));
    ready = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done) done_seen++;
    end
    checkOutput("bp_done_pulses", REC_BITS'(done_seen), REC_BITS'(1));

    // Address wrap with three-cycle ROM latency
    base_addr = 12'hFF8; num_classifiers = 8'd1; ready = 1'b1; start_l3 = 1'b1;
    bad = 0; cyc = -1; done_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) start_l3 = 1'b0;
      if (c <= 18) begin
        a = 12'hFF8 + 12'(c - 1);
        if (rom_address_l3 !== a) bad++;
      end
      if (record_valid_l3 && cyc < 0) begin
        cyc = c;
        for (int k = 0; k < 18; k++) begin
          a = 12'hFF8 + 12'(k);
          if (record_l3[k*8 +: 8] !== a[7:0]) bad++;
        end
      end
      if (done_l3) done_seen = c;
    end
    checkOutput("wrap_address_and_data_errors", REC_BITS'(bad), '0);
    checkOutput("wrap_valid_cycle", REC_BITS'(cyc), REC_BITS'(22));
    checkOutput("wrap_done_cycle", REC_BITS'(done_seen), REC_BITS'(24));

    // Reset in cycle 5 of a fetch abandons the stage
    applyStimulus(1'b1, 12'h100, 8'd2, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) start = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_address", REC_BITS'(rom_address), '0);
    checkOutput("abort_record", record, '0);
    checkOutput("abort_flags", REC_BITS'({record_valid, last, busy, done, checksum_err, index}), '0);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done || record_valid || busy) bad++;
    end
    checkOutput("abort_quiet_cycles", REC_BITS'(bad), '0);
    runStage(12'h100, 8'd2, 20, 42, 36, -1);

    // Checksum: record 0 XORs to zero, record 1 has one bit of word 3 flipped
    flip = 1'b1;
    applyStimulus(1'b1, 12'h200, 8'd2, 1'b1);
    cyc = 0; bad = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (record_valid) begin
        if (cyc == 0) checkOutput("csum_record0_err", REC_BITS'(checksum_err), '0);
        if (cyc == 1) begin
          checkOutput("csum_record1_err", REC_BITS'(checksum_err), REC_BITS'(CSUM_ON));
          checkOutput("csum_record1_word3", REC_BITS'(record[31:24]), REC_BITS'(8'hAD));
        end
        cyc++;
      end else if (checksum_err) begin
        bad++;
      end
    end
    checkOutput("csum_records", REC_BITS'(cyc), REC_BITS'(2));
    checkOutput("csum_err_without_valid", REC_BITS'(bad), '0);
    flip = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
